// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory load/store unit.
package dm_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} lsu_state_t;

  // Store byte-lane enables for a given size and lane; zero for non-store encodings.
  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] lane);
    logic [3:0] be;
    case (funct3)
      F3_B:    be = 4'b0001 << lane;
      F3_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Misalignment or an encoding that is illegal for the access direction.
  function automatic logic access_err(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] lane);
    logic e;
    case (funct3)
      F3_B:    e = 1'b0;
      F3_H:    e = lane[0];
      F3_W:    e = (lane != 2'b00);
      F3_BU:   e = we;
      F3_HU:   e = we | lane[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Store data replicated across lanes so the byte enables pick the right slice.
  function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
    logic [31:0] d;
    case (funct3)
      F3_B:    d = {4{wdata[7:0]}};
      F3_H:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dm_load_align.sv
// Load formatter: lane select plus sign/zero extension of a RAM word.
module dm_load_align
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  output logic [31:0] rdata
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  // Pick the addressed byte/halfword and extend according to funct3[2].
  always_comb begin
    shifted = word >> {lane, 3'b000};
    b       = shifted[7:0];
    h       = lane[1] ? word[31:16] : word[15:0];
    rdata   = '0;
    case (funct3)
      F3_B:    rdata = {{24{b[7]}}, b};
      F3_BU:   rdata = {24'd0, b};
      F3_H:    rdata = {{16{h[15]}}, h};
      F3_HU:   rdata = {16'd0, h};
      F3_W:    rdata = word;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/datamemory_lsu.sv
// Handshaked load/store unit with an internal byte-lane RAM and optional wait states.
module datamemory_lsu
  import dm_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  if (DATA_W != 32) begin : g_bad_data_w
    $error("datamemory_lsu: DATA_W must be 32");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("datamemory_lsu: WAIT_CYCLES must be 0..15");
  end

  lsu_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] rd_word_q;
  logic [DATA_W-1:0] ld_data;
  logic              err_c;
  logic [3:0]        be_c;
  logic [DATA_W-1:0] wr_c;
  logic              ram_wr;
  logic [ADDR_W-3:0] idx;

  assign idx    = addr_q[ADDR_W-1:2];
  assign err_c  = access_err(we_q, f3_q, addr_q[1:0]);
  assign be_c   = byte_en(f3_q, addr_q[1:0]);
  assign wr_c   = store_data(f3_q, wdata_q);
  assign ram_wr = (state_q == ACCESS) && we_q && !err_c;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  dm_load_align u_align (
    .word   (rd_word_q),
    .funct3 (f3_q),
    .lane   (addr_q[1:0]),
    .rdata  (ld_data)
  );

  // Single-cycle RAM access: byte-enabled write and word read in the ACCESS state only.
  always_ff @(posedge clk) begin
    if (state_q == ACCESS) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (ram_wr && be_c[i]) ram[idx][8*i +: 8] <= wr_c[8*i +: 8];
      end
      rd_word_q <= ram[idx];
    end
  end

  // Next-state, request latch and registered response generation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    f3_d        = f3_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          f3_d    = req_funct3;
          wdata_d = req_wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ACCESS: state_d = RESP;
      RESP: begin
        // First RESP cycle formats the word read at the ACCESS edge; then hold until taken.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_c;
          rsp_rdata_d = (err_c || we_q) ? '0 : ld_data;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      f3_q        <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      f3_q        <= f3_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule
